// File: rtl/an_code_pkg.sv
// Shared AN-code constants, FSM state type and codeword-width helper.
// Used by the sequential encoder and by the matching AN decoder.
package an_code_pkg;

    localparam int unsigned A_DEFAULT = 29;
    localparam int unsigned A_W       = 5;
    localparam int unsigned N_W       = 9;
    localparam int unsigned AN_W      = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } an_state_e;

    // Bits needed to hold A * (2^n_w - 1), the largest possible codeword.
    function automatic int unsigned min_an_w(input int unsigned a, input int unsigned n_w);
        longint unsigned prod;
        int unsigned     w;
        prod = 64'(a) * ((64'd1 << n_w) - 64'd1);
        w    = 0;
        for (int i = 0; i < 64; i++) begin
            if (prod[i]) begin
                w = 32'(i) + 32'd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/an_shift_add_mul.sv
// Iterative shift-and-add multiplier by the constant A, one bit of A per cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       load mcand_i, clear accumulator, begin stepping
//   mcand_i       multiplicand, already zero-extended to AN_W
//   done_c_o      high during the final step (combinational)
//   acc_nxt_c_o   accumulator value after the current step (combinational)
module an_shift_add_mul #(
    parameter int unsigned A    = an_code_pkg::A_DEFAULT,
    parameter int unsigned A_W  = an_code_pkg::A_W,
    parameter int unsigned AN_W = an_code_pkg::AN_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [AN_W-1:0] mcand_i,
    output logic            done_c_o,
    output logic [AN_W-1:0] acc_nxt_c_o
);
    import an_code_pkg::*;

    localparam int unsigned         STEP_W    = (A_W > 1) ? $clog2(A_W) : 1;
    localparam logic [A_W-1:0]      A_BITS    = A_W'(A);
    localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(A_W - 1);

    logic [AN_W-1:0]   mcand_q;
    logic [AN_W-1:0]   acc_q;
    logic [AN_W-1:0]   acc_d;
    logic [STEP_W-1:0] step_q;
    logic              run_q;

    // Partial product for the current bit of A; the codeword width guarantees no overflow.
    always_comb begin
        acc_d = acc_q;
        if (A_BITS[step_q]) begin
            acc_d = acc_q + (mcand_q << step_q);
        end
    end

    assign done_c_o    = run_q && (step_q == LAST_STEP);
    assign acc_nxt_c_o = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            run_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q <= mcand_i;
            acc_q   <= '0;
            step_q  <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_d;
            if (step_q == LAST_STEP) begin
                run_q <= 1'b0;
            end else begin
                step_q <= step_q + STEP_W'(1);
            end
        end
    end

endmodule

// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder: an_out = (A * n_in) ^ err_mask, valid/ready on both sides.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    input handshake carrying n_in and err_mask
//   n_in                   data word N
//   err_mask               codeword bits to flip (models channel errors)
//   out_valid / out_ready  output handshake carrying an_out
//   an_out                 registered codeword, held while stalled
//   busy                   a word is in flight
//   xfer_cnt               completed output handshakes, wraps
module an_encoder_seq #(
    parameter int unsigned A     = an_code_pkg::A_DEFAULT,
    parameter int unsigned A_W   = an_code_pkg::A_W,
    parameter int unsigned N_W   = an_code_pkg::N_W,
    parameter int unsigned AN_W  = an_code_pkg::AN_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_W-1:0]   n_in,
    input  logic [AN_W-1:0]  err_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AN_W-1:0]  an_out,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);
    import an_code_pkg::*;

    // Reject parameter sets that would let the product overflow the codeword.
    if (AN_W < min_an_w(A, N_W)) begin : g_bad_an_w
        $error("an_encoder_seq: AN_W too small for A*(2^N_W-1)");
    end
    if ((A < 3) || ((A % 2) == 0) || (A >= (1 << A_W))) begin : g_bad_a
        $error("an_encoder_seq: A must be odd, greater than 1 and fit in A_W bits");
    end

    an_state_e        state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [AN_W-1:0]  an_out_q;
    logic [AN_W-1:0]  mask_q;
    logic [CNT_W-1:0] xfer_cnt_q;

    logic             start_c;
    logic             mul_done_c;
    logic [AN_W-1:0]  mul_acc_c;

    assign start_c = (state_q == IDLE) && in_valid && in_ready_q;

    an_shift_add_mul #(
        .A    (A),
        .A_W  (A_W),
        .AN_W (AN_W)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_c),
        .mcand_i     (AN_W'(n_in)),
        .done_c_o    (mul_done_c),
        .acc_nxt_c_o (mul_acc_c)
    );

    // Control FSM; the final multiplier step lands straight in the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            an_out_q    <= '0;
            mask_q      <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        mask_q     <= err_mask;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (mul_done_c) begin
                        an_out_q    <= mul_acc_c ^ mask_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Input stays blocked this cycle; it is taken in the following IDLE cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        xfer_cnt_q  <= xfer_cnt_q + CNT_W'(1);
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign an_out    = an_out_q;
    assign busy      = busy_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_an_encoder_seq.sv
// Self-checking bench for an_encoder_seq: vector table, scoreboard, corner-case sequences.
module tb_an_encoder_seq;

    localparam int LAT    = 6;   // handshake cycle to first out_valid
    localparam int PERIOD = 7;   // back-to-back output spacing

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  n_in;
    logic [13:0] err_mask;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] an_out;
    logic        busy;
    logic [15:0] xfer_cnt;

    an_encoder_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n_in      (n_in),
        .err_mask  (err_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .an_out    (an_out),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [13:0] exp;
        int          hs_cyc;
    } sb_t;
    sb_t sb_q[$];
    int  out_cyc_q[$];

    logic [13:0] exp_cur = '0;
    logic        prev_ov = 1'b0;

    typedef struct {
        logic [8:0]  n;
        logic [13:0] mask;
        logic [13:0] exp;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: push on input handshake, check latency on out_valid rise, pop on output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (sb_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
                else                  chk("latency", cyc - sb_q[0].hs_cyc, LAT);
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
                chk("an_out", an_out, sb_q[0].exp);
                void'(sb_q.pop_front());
                out_cyc_q.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                sb_q.push_back('{exp_cur, cyc});
            end
        end
        prev_ov = out_valid;
    end

    // Present a word and hold in_valid until the handshake edge has passed.
    task automatic send(input logic [8:0] n, input logic [13:0] m, input logic [13:0] e);
        bit ok;
        ok       = 1'b0;
        n_in     = n;
        err_mask = m;
        exp_cur  = e;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_x;
        int          base;
        bit          seen;
        logic [13:0] held;

        // 29*n ^ mask, worked out by hand
        vecs[0] = '{9'd0,   14'h0000, 14'd0};
        vecs[1] = '{9'd1,   14'h0000, 14'd29};
        vecs[2] = '{9'd511, 14'h0000, 14'd14819};
        vecs[3] = '{9'd5,   14'h0001, 14'd144};
        vecs[4] = '{9'd3,   14'h0000, 14'd87};
        vecs[5] = '{9'd100, 14'h0000, 14'd2900};
        vecs[6] = '{9'd200, 14'h2000, 14'd13992};
        vecs[7] = '{9'd17,  14'h3FFF, 14'd15890};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_in      = '0;
        err_mask  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_an_out",    an_out,    0);
        chk("rst_busy",      busy,      0);
        chk("rst_xfer_cnt",  xfer_cnt,  0);
        rst = 1'b0;

        // Reset during CALC step 2 aborts the word.
        out_ready = 1'b1;
        send(9'd9, 14'h0000, 14'd261);
        in_valid = 1'b0;
        chk("calc_busy",     busy,     1);
        chk("calc_in_ready", in_ready, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        chk("abort_in_ready",  in_ready,  1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy",      busy,      0);
        chk("abort_xfer_cnt",  xfer_cnt,  0);
        repeat (8) @(negedge clk);
        chk("abort_no_output", out_valid, 0);
        @(posedge clk);
        #1;
        send(9'd3, 14'h0000, 14'd87);
        in_valid = 1'b0;
        drain();
        exp_x = 1;
        chk("post_abort_xfer", xfer_cnt, exp_x);

        // Vector table, one word at a time.
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].n, vecs[v].mask, vecs[v].exp);
            in_valid = 1'b0;
            drain();
            exp_x++;
            chk("vec_xfer_cnt", xfer_cnt, exp_x);
        end

        // Backpressure: output held, input blocked, new in_valid ignored.
        out_ready = 1'b0;
        send(9'd7, 14'h0000, 14'd203);
        in_valid = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("bp_out_valid_timeout", out_valid, 1);
        held = an_out;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        n_in     = 9'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_an_out",    an_out,    held);
            chk("bp_in_ready",  in_ready,  0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        exp_x++;
        chk("bp_xfer_cnt", xfer_cnt, exp_x);

        // Back-to-back with in_valid and out_ready held high.
        base = out_cyc_q.size();
        send(9'd1, 14'h0000, 14'd29);
        send(9'd2, 14'h0000, 14'd58);
        send(9'd3, 14'h0000, 14'd87);
        in_valid = 1'b0;
        drain();
        exp_x += 3;
        chk("b2b_xfer_cnt", xfer_cnt, exp_x);
        chk("b2b_count", out_cyc_q.size() - base, 3);
        if (out_cyc_q.size() >= base + 3) begin
            chk("b2b_spacing_1", out_cyc_q[base+1] - out_cyc_q[base],   PERIOD);
            chk("b2b_spacing_2", out_cyc_q[base+2] - out_cyc_q[base+1], PERIOD);
        end
        chk("end_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/an_encoder_seq.md
Name: an_encoder_seq

Overview:
- Sequential AN-code encoder. It sits directly upstream of the AN decoder in the BER test chain.
- It accepts a data word N and computes the codeword AN = A*N with an iterative shift-and-add multiplier.
- It then applies an optional error mask that models channel bit flips, and presents the codeword for the decoder to consume.
- Input and output both use valid/ready handshakes. A transfer counter supports BER bookkeeping.

Parameters:
- A, 29, code constant. Odd and greater than 1.
- A_W, 5, bit width of A. This is also the number of CALC cycles.
- N_W, 9, data word width.
- AN_W, 14, codeword width. Elaboration check: A*(2^N_W-1) < 2^AN_W must hold, otherwise elaboration fails.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  n_in and err_mask are valid
- in_ready  out  1  encoder can accept a word
- n_in  in  N_W  data word N
- err_mask  in  AN_W  bits to flip in the codeword (0 = clean)
- out_valid  out  1  an_out is valid
- out_ready  in  1  downstream (decoder side) accepts
- an_out  out  AN_W  (A*N) XOR err_mask
- busy  out  1  state != IDLE
- xfer_cnt  out  CNT_W  count of completed output handshakes

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE. in_ready=1 from the next cycle. out_valid=0, an_out=0, busy=0, xfer_cnt=0.
  - Internal accumulator, multiplicand, mask and step counter are cleared.
  - Reset mid-CALC or mid-DONE aborts the word with no output. The counter is not incremented.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch mcand=zero-extended n_in (AN_W), mask=err_mask, acc=0, step=0. Go to CALC.
- CALC (exactly A_W cycles, in_ready=0):
  - Each cycle: if A[step]=1 then acc <= acc + (mcand << step), truncated to AN_W. Then step++.
  - When step==A_W-1 the final add is performed and the state goes to DONE.
  - The sum cannot overflow, given the elaboration check.
- DONE:
  - out_valid=1, an_out=acc^mask. Both are registered and stable while out_ready=0.
  - On out_ready=1: out_valid=0 and xfer_cnt++. Go to IDLE.
- Latency: input handshake in cycle 0; out_valid first high in cycle A_W+1 (cycle 6 with defaults).
- Throughput: one word per A_W+2 cycles with out_ready tied high.
- in_ready=0 in CALC and DONE. in_valid in those states is ignored, and no value is captured.
- xfer_cnt wraps modulo 2^CNT_W.
- out_ready while out_valid=0 has no effect.
- n_in and err_mask are sampled only on the input handshake. Later changes do not affect the word in flight.
- Simultaneous out handshake in DONE and in_valid: the input is not accepted that cycle. It is accepted in the following IDLE cycle.

Decomposition:
- Shared package an_code_pkg holds:
  - constants A_DEFAULT=29, A_W, N_W, AN_W;
  - the FSM state enum {IDLE, CALC, DONE};
  - a function that computes the minimum AN_W, for the elaboration check. The decoder package reuses the same constants.
- One natural sub-module: an_shift_add_mul (acc/step datapath with a start/done interface). The FSM and handshake stay in the top level.

Test Plan:
- n_in=0, mask=0 -> an_out=0 at cycle 6; xfer_cnt=1.
- n_in=1 -> 29 (0x001D). n_in=511 -> 14819 (0x39E3). Each appears exactly 6 cycles after its handshake.
- n_in=5, mask=0x0001 -> an_out=144 (145^1). Feeding 144 to the decoder yields 5 again.
- Backpressure: out_ready low for 10 cycles -> an_out and out_valid are held stable, in_ready stays 0, and a new in_valid is ignored. After out_ready rises, xfer_cnt increments by exactly 1.
- Reset asserted in CALC step 2 -> the next cycle is IDLE, out_valid=0, xfer_cnt unchanged. A subsequent n_in=3 gives 87.
- Back-to-back: in_valid and out_ready held high over 3 words (n=1,2,3) -> outputs 29, 58, 87, spaced 7 cycles apart; xfer_cnt=3.
